// File: rtl/bullet_slot_arbiter.sv
// Shares NUM_SLOTS bullet slots between two players: edge-detected fire requests,
// per-player cooldown and live-bullet cap. Define BULLET_ARB_AUTOFIRE_EN for hold-to-fire.
module bullet_slot_arbiter #(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         round_reset_i,
  input  logic                         tick_i,
  input  logic [1:0]                   shoot_req_i,
  input  logic [NUM_SLOTS-1:0]         slot_release_i,
  output logic [1:0]                   grant_o,
  output logic [$clog2(NUM_SLOTS)-1:0] grant_slot_o,
  output logic [NUM_SLOTS-1:0]         slot_busy_o,
  output logic [NUM_SLOTS-1:0]         slot_owner_o,
  output logic [1:0]                   cooldown_active_o
);

  // state      | meaning
  // ST_IDLE    | no request outstanding
  // ST_PENDING | fire edge seen, waiting for arbitration
  // ST_GRANT   | launch grant presented for one cycle
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(COOLDOWN_TICKS + 2);
  localparam int LW = $clog2(NUM_SLOTS + 1);

  logic [1:0][1:0]    state, state_nxt;
  logic [1:0][CW-1:0] cooldown;
  logic [1:0]         shoot_q;
  logic               tick_q;
  logic               rr_ptr;
  logic [NUM_SLOTS-1:0] busy, owner;
  logic [SW-1:0]      grant_slot_q;

  logic [1:0]         req_edge, req_set, pending, eligible, cand, win;
  logic               tick_edge, free_any;
  logic [SW-1:0]      free_idx;
  logic [LW-1:0]      live0, live1;
  logic [NUM_SLOTS-1:0] grant_mask;

  assign req_edge  = shoot_req_i & ~shoot_q;
  assign tick_edge = tick_i & ~tick_q;
  assign free_any  = ~&busy;

`ifdef BULLET_ARB_AUTOFIRE_EN
  assign req_set[0] = req_edge[0] | (shoot_req_i[0] & (cooldown[0] == '0));
  assign req_set[1] = req_edge[1] | (shoot_req_i[1] & (cooldown[1] == '0));
`else
  assign req_set = req_edge;
`endif

  always_comb begin
    free_idx = '0;
    live0    = '0;
    live1    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = SW'(i);
      live0 = live0 + LW'(busy[i] & ~owner[i]);
      live1 = live1 + LW'(busy[i] & owner[i]);
    end
  end

  always_comb begin
    pending[0]  = (state[0] == ST_PENDING);
    pending[1]  = (state[1] == ST_PENDING);
    eligible[0] = (cooldown[0] == '0) && (live0 < LW'(MAX_PER_PLAYER)) && free_any;
    eligible[1] = (cooldown[1] == '0) && (live1 < LW'(MAX_PER_PLAYER)) && free_any;
    cand        = pending & eligible;
    // Contested: rr_ptr names the winner; otherwise the lone candidate wins.
    if (cand == 2'b11) win = rr_ptr ? 2'b10 : 2'b01;
    else               win = cand;
    grant_mask = (win != 2'b00) ? (NUM_SLOTS'(1) << free_idx) : '0;
  end

  always_comb begin
    state_nxt = state;
    for (int p = 0; p < 2; p++) begin
      if (state[p] == ST_PENDING) begin
        if (win[p])       state_nxt[p] = ST_GRANT;
        else if (cand[p]) state_nxt[p] = ST_PENDING;
        else              state_nxt[p] = ST_IDLE;
      end else begin
        state_nxt[p] = req_set[p] ? ST_PENDING : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= '0;
      cooldown     <= '0;
      shoot_q      <= '0;
      tick_q       <= 1'b0;
      rr_ptr       <= 1'b0;
      busy         <= '0;
      owner        <= '0;
      grant_slot_q <= '0;
    end else if (round_reset_i) begin
      state        <= '0;
      cooldown     <= '0;
      shoot_q      <= '0;
      tick_q       <= 1'b0;
      rr_ptr       <= 1'b0;
      busy         <= '0;
      owner        <= '0;
      grant_slot_q <= '0;
    end else begin
      state   <= state_nxt;
      shoot_q <= shoot_req_i;
      tick_q  <= tick_i;
      if (cand == 2'b11) rr_ptr <= ~rr_ptr;
      // Released slots only become grantable from the next cycle's registered busy.
      busy <= (busy & ~slot_release_i) | grant_mask;
      if (win != 2'b00) owner[free_idx] <= win[1];
      grant_slot_q <= (win != 2'b00) ? free_idx : '0;
      for (int p = 0; p < 2; p++) begin
        if (win[p])
          cooldown[p] <= CW'(COOLDOWN_TICKS);
        else if (tick_edge && (cooldown[p] != '0))
          cooldown[p] <= cooldown[p] - CW'(1);
      end
    end
  end

  assign grant_o[0]           = (state[0] == ST_GRANT);
  assign grant_o[1]           = (state[1] == ST_GRANT);
  assign grant_slot_o         = grant_slot_q;
  assign slot_busy_o          = busy;
  assign slot_owner_o         = owner;
  assign cooldown_active_o[0] = (cooldown[0] != '0);
  assign cooldown_active_o[1] = (cooldown[1] != '0);

endmodule
